// File: rtl/boss_pkg.sv
// Shared boss types and default tuning constants for boss_ctrl and boss_move.
package boss_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PATROL = 3'd1,
        JUMP   = 3'd2,
        DEAD   = 3'd3
    } boss_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int DEF_HP_MAX        = 100;
    localparam int DEF_START_X       = 800;
    localparam int DEF_GROUND_Y      = 600;
    localparam int DEF_X_MIN         = 106;
    localparam int DEF_X_MAX         = 918;
    localparam int DEF_SPEED         = 2;
    localparam int DEF_JUMP_V        = 12;
    localparam int DEF_GRAVITY       = 1;
    localparam int DEF_JUMP_PERIOD   = 120;
    localparam int DEF_INVULN_FRAMES = 30;

endpackage

// File: rtl/boss_move.sv
// Combinational per-frame motion step: horizontal walk with edge bounce,
// and jump ballistics with landing detection.
module boss_move
    import boss_pkg::*;
#(
    parameter int X_MIN    = DEF_X_MIN,
    parameter int X_MAX    = DEF_X_MAX,
    parameter int GROUND_Y = DEF_GROUND_Y,
    parameter int GRAVITY  = DEF_GRAVITY
) (
    input  boss_state_t        state,
    input  logic [11:0]        x,
    input  logic [11:0]        y,
    input  logic signed [7:0]  vel,
    input  logic               dir,
    input  logic [7:0]         speed,
    output logic [11:0]        x_nxt,
    output logic [11:0]        y_nxt,
    output logic signed [7:0]  vel_nxt,
    output logic               dir_nxt,
    output logic               landed
);

    localparam logic signed [12:0] X_LO  = 13'(X_MIN);
    localparam logic signed [12:0] X_HI  = 13'(X_MAX);
    localparam logic signed [12:0] Y_GND = 13'(GROUND_Y);
    localparam logic signed [7:0]  GRAV  = 8'(GRAVITY);

    logic signed [12:0] x_sum;
    logic signed [12:0] y_sum;

    // Reaching either edge exactly counts as a bounce, so the boss turns there.
    always_comb begin
        x_nxt   = x;
        y_nxt   = y;
        vel_nxt = vel;
        dir_nxt = dir;
        landed  = 1'b0;

        if (dir == DIR_LEFT)
            x_sum = $signed({1'b0, x}) - $signed({5'b0, speed});
        else
            x_sum = $signed({1'b0, x}) + $signed({5'b0, speed});
        y_sum = $signed({1'b0, y}) - $signed({{5{vel[7]}}, vel});

        if (x_sum <= X_LO) begin
            x_nxt   = 12'(X_MIN);
            dir_nxt = DIR_RIGHT;
        end else if (x_sum >= X_HI) begin
            x_nxt   = 12'(X_MAX);
            dir_nxt = DIR_LEFT;
        end else begin
            x_nxt = x_sum[11:0];
        end

        if (state == JUMP) begin
            if ((y_sum >= Y_GND) && (vel <= 8'sd0)) begin
                landed  = 1'b1;
                y_nxt   = 12'(GROUND_Y);
                vel_nxt = 8'sd0;
            end else begin
                y_nxt   = y_sum[11:0];
                vel_nxt = vel - GRAV;
            end
        end
    end

endmodule

// File: rtl/boss_ctrl.sv
// Boss sequencer: frame-stepped patrol/jump/dead FSM, hit points and damage handshake.
// Optional build macro BOSS_ENRAGE_EN doubles speed and halves the jump period at half health.
module boss_ctrl
    import boss_pkg::*;
#(
    parameter int HP_MAX        = DEF_HP_MAX,
    parameter int START_X       = DEF_START_X,
    parameter int GROUND_Y      = DEF_GROUND_Y,
    parameter int X_MIN         = DEF_X_MIN,
    parameter int X_MAX         = DEF_X_MAX,
    parameter int SPEED         = DEF_SPEED,
    parameter int JUMP_V        = DEF_JUMP_V,
    parameter int GRAVITY       = DEF_GRAVITY,
    parameter int JUMP_PERIOD   = DEF_JUMP_PERIOD,
    parameter int INVULN_FRAMES = DEF_INVULN_FRAMES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  game_active,
    input  logic        frame_tick,
    input  logic        hit_req,
    input  logic [3:0]  hit_dmg,
    output logic        hit_ack,
    output logic [11:0] boss_x,
    output logic [11:0] boss_y,
    output logic [6:0]  boss_hp,
    output logic [2:0]  boss_state
);

    boss_state_t       state;
    logic [11:0]       x, y;
    logic [6:0]        hp;
    logic              dir;
    logic signed [7:0] vel;
    logic [7:0]        jump_cnt;
    logic [7:0]        invuln_cnt;
    logic              ack;

    logic [11:0]       x_nxt, y_nxt;
    logic signed [7:0] vel_nxt;
    logic              dir_nxt;
    logic              landed;
    logic [7:0]        speed;
    logic [7:0]        jump_thr;
    logic              hit_take;
    logic              hit_accept;
    logic [6:0]        hp_after;

`ifdef BOSS_ENRAGE_EN
    logic enraged;
    assign enraged  = (hp != 7'd0) && (hp <= 7'(HP_MAX / 2));
    assign speed    = enraged ? 8'(2 * SPEED) : 8'(SPEED);
    assign jump_thr = enraged ? 8'(JUMP_PERIOD / 2) : 8'(JUMP_PERIOD);
`else
    assign speed    = 8'(SPEED);
    assign jump_thr = 8'(JUMP_PERIOD);
`endif

    assign hit_take   = hit_req & ~ack;
    assign hit_accept = hit_take && ((state == PATROL) || (state == JUMP)) && (invuln_cnt == 8'd0);
    assign hp_after   = (hp < {3'b0, hit_dmg}) ? 7'd0 : hp - {3'b0, hit_dmg};

    boss_move #(
        .X_MIN    (X_MIN),
        .X_MAX    (X_MAX),
        .GROUND_Y (GROUND_Y),
        .GRAVITY  (GRAVITY)
    ) u_move (
        .state   (state),
        .x       (x),
        .y       (y),
        .vel     (vel),
        .dir     (dir),
        .speed   (speed),
        .x_nxt   (x_nxt),
        .y_nxt   (y_nxt),
        .vel_nxt (vel_nxt),
        .dir_nxt (dir_nxt),
        .landed  (landed)
    );

    // A killing hit is applied last so DEAD overrides any movement transition.
    always_ff @(posedge clk) begin
        if (rst || (game_active != 2'd1)) begin
            state      <= IDLE;
            x          <= 12'(START_X);
            y          <= 12'(GROUND_Y);
            hp         <= 7'(HP_MAX);
            dir        <= DIR_LEFT;
            vel        <= 8'sd0;
            jump_cnt   <= 8'd0;
            invuln_cnt <= 8'd0;
            ack        <= 1'b0;
        end else begin
            ack <= hit_take;

            if (frame_tick && (invuln_cnt != 8'd0))
                invuln_cnt <= invuln_cnt - 8'd1;
            if (hit_accept) begin
                hp         <= hp_after;
                invuln_cnt <= 8'(INVULN_FRAMES);
            end

            case (state)
                IDLE: state <= PATROL;
                PATROL: begin
                    if (frame_tick) begin
                        x   <= x_nxt;
                        dir <= dir_nxt;
                        if (jump_cnt >= jump_thr - 8'd1) begin
                            jump_cnt <= 8'd0;
                            vel      <= 8'(JUMP_V);
                            state    <= JUMP;
                        end else begin
                            jump_cnt <= jump_cnt + 8'd1;
                        end
                    end
                end
                JUMP: begin
                    if (frame_tick) begin
                        x   <= x_nxt;
                        dir <= dir_nxt;
                        y   <= y_nxt;
                        vel <= vel_nxt;
                        if (landed)
                            state <= PATROL;
                    end
                end
                default: ;
            endcase

            if (hit_accept && (hp_after == 7'd0))
                state <= DEAD;
        end
    end

    assign hit_ack    = ack;
    assign boss_x     = x;
    assign boss_y     = y;
    assign boss_hp    = hp;
    assign boss_state = state;

endmodule

// File: tb/tb_boss_ctrl.sv
// Directed bench for boss_ctrl: reset, patrol, edge bounce, jump arc, damage handshake and death.
// Expectations follow BOSS_ENRAGE_EN when the bench is built with it.
module tb_boss_ctrl;
    import boss_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  game_active;
    logic        frame_tick;
    logic        hit_req;
    logic [3:0]  hit_dmg;
    logic        hit_ack;
    logic [11:0] boss_x;
    logic [11:0] boss_y;
    logic [6:0]  boss_hp;
    logic [2:0]  boss_state;

    int compared   = 0;
    int mismatched = 0;

    boss_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .game_active (game_active),
        .frame_tick  (frame_tick),
        .hit_req     (hit_req),
        .hit_dmg     (hit_dmg),
        .hit_ack     (hit_ack),
        .boss_x      (boss_x),
        .boss_y      (boss_y),
        .boss_hp     (boss_hp),
        .boss_state  (boss_state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Issue n frame ticks; returns on the falling edge after the last one.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
        end
    endtask

    task automatic sendHit(input logic [3:0] dmg, input logic with_tick);
        @(negedge clk);
        hit_req    = 1'b1;
        hit_dmg    = dmg;
        frame_tick = with_tick;
        @(negedge clk);
        frame_tick = 1'b0;
        checkOutput("hit_ack_pulse", 32'(hit_ack), 32'd1);
        @(posedge clk);
        #1 hit_req = 1'b0;
        @(negedge clk);
        checkOutput("hit_ack_once", 32'(hit_ack), 32'd0);
    endtask

    initial begin
        rst = 1'b1; game_active = 2'd1; frame_tick = 1'b0; hit_req = 1'b0; hit_dmg = 4'd0;
        repeat (2) @(negedge clk);
        checkOutput("rst_state", 32'(boss_state), 32'(IDLE));
        checkOutput("rst_x", 32'(boss_x), 32'd800);
        checkOutput("rst_y", 32'(boss_y), 32'd600);
        checkOutput("rst_hp", 32'(boss_hp), 32'd100);
        checkOutput("rst_ack", 32'(hit_ack), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_to_patrol", 32'(boss_state), 32'(PATROL));

        applyStimulus(3);
        checkOutput("patrol3_x", 32'(boss_x), 32'd794);
        checkOutput("patrol3_y", 32'(boss_y), 32'd600);
        checkOutput("patrol3_hp", 32'(boss_hp), 32'd100);
        checkOutput("patrol3_state", 32'(boss_state), 32'(PATROL));

        // Walk to the left edge: jumps do not disturb the horizontal walk.
        applyStimulus(343);
        checkOutput("edge_x108", 32'(boss_x), 32'd108);
        applyStimulus(1);
        checkOutput("edge_clamp", 32'(boss_x), 32'd106);
        applyStimulus(1);
        checkOutput("edge_bounce", 32'(boss_x), 32'd108);
        checkOutput("edge_state", 32'(boss_state), 32'(PATROL));

        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        checkOutput("rerst_x", 32'(boss_x), 32'd800);
        applyStimulus(3);
        sendHit(4'd10, 1'b0);
        checkOutput("hit10_hp", 32'(boss_hp), 32'd90);
        sendHit(4'd5, 1'b0);
        checkOutput("invuln_hp", 32'(boss_hp), 32'd90);
        applyStimulus(30);
        sendHit(4'd15, 1'b0);
        checkOutput("hit15_hp", 32'(boss_hp), 32'd75);
        applyStimulus(30);
        sendHit(4'd15, 1'b0);
        checkOutput("hit15b_hp", 32'(boss_hp), 32'd60);
        applyStimulus(30);
        sendHit(4'd10, 1'b0);
        checkOutput("half_hp", 32'(boss_hp), 32'd50);
        checkOutput("half_x", 32'(boss_x), 32'd614);

`ifdef BOSS_ENRAGE_EN
        applyStimulus(1);
        checkOutput("enrage_x", 32'(boss_x), 32'd610);
        checkOutput("enrage_jump", 32'(boss_state), 32'(JUMP));
        checkOutput("jump_y0", 32'(boss_y), 32'd600);
        applyStimulus(1);
        checkOutput("jump_y1", 32'(boss_y), 32'd588);
        applyStimulus(1);
        checkOutput("jump_y2", 32'(boss_y), 32'd577);
        applyStimulus(1);
        checkOutput("jump_y3", 32'(boss_y), 32'd567);
        checkOutput("jump_x3", 32'(boss_x), 32'd598);
`else
        applyStimulus(1);
        checkOutput("speed_x", 32'(boss_x), 32'd612);
        applyStimulus(25);
        checkOutput("pre_jump_state", 32'(boss_state), 32'(PATROL));
        checkOutput("pre_jump_x", 32'(boss_x), 32'd562);
        applyStimulus(1);
        checkOutput("jump_state", 32'(boss_state), 32'(JUMP));
        checkOutput("jump_y0", 32'(boss_y), 32'd600);
        applyStimulus(1);
        checkOutput("jump_y1", 32'(boss_y), 32'd588);
        applyStimulus(1);
        checkOutput("jump_y2", 32'(boss_y), 32'd577);
        applyStimulus(1);
        checkOutput("jump_y3", 32'(boss_y), 32'd567);
        checkOutput("jump_x3", 32'(boss_x), 32'd554);
`endif
        applyStimulus(22);
        checkOutput("land_state", 32'(boss_state), 32'(PATROL));
        checkOutput("land_y", 32'(boss_y), 32'd600);
        checkOutput("land_x", 32'(boss_x), 32'd510);

        sendHit(4'd15, 1'b0);
        checkOutput("hit_hp35", 32'(boss_hp), 32'd35);
        applyStimulus(30);
        checkOutput("k30_state", 32'(boss_state), 32'(PATROL));
        sendHit(4'd15, 1'b0);
        checkOutput("hit_hp20", 32'(boss_hp), 32'd20);
        applyStimulus(30);
`ifdef BOSS_ENRAGE_EN
        checkOutput("k60_state", 32'(boss_state), 32'(JUMP));
`else
        checkOutput("k60_state", 32'(boss_state), 32'(PATROL));
`endif
        sendHit(4'd15, 1'b0);
        checkOutput("hit_hp5", 32'(boss_hp), 32'd5);
        applyStimulus(30);
        sendHit(4'd9, 1'b1);
        checkOutput("kill_hp", 32'(boss_hp), 32'd0);
        checkOutput("kill_state", 32'(boss_state), 32'(DEAD));
`ifdef BOSS_ENRAGE_EN
        checkOutput("kill_x", 32'(boss_x), 32'd146);
`else
        checkOutput("kill_x", 32'(boss_x), 32'd328);
`endif
        checkOutput("kill_y", 32'(boss_y), 32'd600);

        applyStimulus(3);
`ifdef BOSS_ENRAGE_EN
        checkOutput("dead_x", 32'(boss_x), 32'd146);
`else
        checkOutput("dead_x", 32'(boss_x), 32'd328);
`endif
        checkOutput("dead_y", 32'(boss_y), 32'd600);
        checkOutput("dead_state", 32'(boss_state), 32'(DEAD));
        sendHit(4'd3, 1'b0);
        checkOutput("dead_hp", 32'(boss_hp), 32'd0);

        @(negedge clk) game_active = 2'd0;
        @(negedge clk);
        checkOutput("inactive_state", 32'(boss_state), 32'(IDLE));
        checkOutput("inactive_hp", 32'(boss_hp), 32'd100);
        checkOutput("inactive_x", 32'(boss_x), 32'd800);
        game_active = 2'd1;
        @(negedge clk);
        checkOutput("resume_state", 32'(boss_state), 32'(PATROL));
        game_active = 2'd2;
        @(negedge clk);
        checkOutput("mode2_state", 32'(boss_state), 32'(IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
